// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, bubble word, opcode constants and the
// fetch-unit state encoding.
package pipeline_pkg;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned INST_W = 16;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_IMD   = 4'b0011;
    localparam logic [3:0] OP_IMM   = 4'b0111;
    localparam logic [3:0] OP_JDI   = 4'b1001;
    // Jump class is identified by instruction bits [15:14].
    localparam logic [1:0] OP_JUMP_CLASS = 2'b11;

    typedef enum logic [1:0] {
        StBoot  = 2'b00,
        StRun   = 2'b01,
        StStall = 2'b10,
        StWait  = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the fetch pointer, issues instruction/PC/bubble count
// to the control unit, and handles stalls, memory waits and jump redirects.
module fetch_unit #(
    parameter int unsigned      PC_W        = 8,
    parameter int unsigned      INST_W      = 16,
    parameter logic [PC_W-1:0]  RESET_PC    = 8'h00,
    parameter logic [INST_W-1:0] NOP_INST   = 16'h0000,
    parameter int unsigned      STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [INST_W-1:0]      imem_rdata,
    input  logic                   imem_valid,
    input  logic                   control,
    input  logic [1:0]             count_out,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_target,
    output logic                   en,
    output logic [INST_W-1:0]      current,
    output logic [PC_W-1:0]        PC,
    output logic [1:0]             count,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    import pipeline_pkg::*;

    fetch_state_e    state;
    logic [PC_W-1:0] fpc;
    logic            stall_inc;

    assign imem_addr = fpc;

    // A redirect in the same cycle cancels the stall, so it is not counted.
    assign stall_inc = (state != StBoot) && !redirect_valid && control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StBoot;
            fpc     <= RESET_PC;
            current <= NOP_INST;
            PC      <= RESET_PC;
            count   <= 2'd0;
            en      <= 1'b0;
        end else begin
            unique case (state)
                StBoot: begin
                    if (imem_valid) begin
                        current <= imem_rdata;
                        PC      <= fpc;
                        fpc     <= fpc + PC_W'(1);
                        en      <= 1'b1;
                        state   <= StRun;
                    end
                end
                StRun, StStall, StWait: begin
                    if (redirect_valid) begin
                        // Squash the in-flight word; PC keeps the old value under the bubble.
                        fpc     <= redirect_target;
                        current <= NOP_INST;
                        count   <= 2'd0;
                        state   <= StRun;
                    end else if (control) begin
                        count <= count_out;
                        state <= StStall;
                    end else if (!imem_valid) begin
                        current <= NOP_INST;
                        count   <= 2'd0;
                        state   <= StWait;
                    end else begin
                        current <= imem_rdata;
                        PC      <= fpc;
                        fpc     <= fpc + PC_W'(1);
                        count   <= 2'd0;
                        state   <= StRun;
                    end
                end
                default: state <= StBoot;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a behavioural model of
// the fetch rules (booted flag, fetch pointer, issued word/PC, count, stall total).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        control;
    logic [1:0]  count_out;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        en;
    logic [15:0] current;
    logic [7:0]  PC;
    logic [1:0]  count;
    logic [15:0] stall_cnt;

    logic [15:0] mem [256];

    logic [7:0]  m_fpc;
    logic [7:0]  m_pc;
    logic [15:0] m_cur;
    logic [1:0]  m_count;
    logic        m_en;
    logic [15:0] m_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_valid      (imem_valid),
        .control         (control),
        .count_out       (count_out),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .en              (en),
        .current         (current),
        .PC              (PC),
        .count           (count),
        .stall_cnt       (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc   = 8'h00;
        m_pc    = 8'h00;
        m_cur   = 16'h0000;
        m_count = 2'd0;
        m_en    = 1'b0;
        m_stall = 16'h0000;
    endtask

    task automatic compare_all();
        check("en", 32'(en), 32'(m_en));
        check("current", 32'(current), 32'(m_cur));
        check("PC", 32'(PC), 32'(m_pc));
        check("count", 32'(count), 32'(m_count));
        check("imem_addr", 32'(imem_addr), 32'(m_fpc));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, then sample.
    task automatic step(input logic iv, input logic ctl, input logic [1:0] co,
                        input logic rv, input logic [7:0] rt, input bit chk);
        @(negedge clk);
        imem_valid      = iv;
        control         = ctl;
        count_out       = co;
        redirect_valid  = rv;
        redirect_target = rt;
        if (!m_en) begin
            if (iv) begin
                m_cur = mem[m_fpc];
                m_pc  = m_fpc;
                m_fpc = m_fpc + 8'd1;
                m_en  = 1'b1;
            end
        end else if (rv) begin
            m_fpc   = rt;
            m_cur   = 16'h0000;
            m_count = 2'd0;
        end else if (ctl) begin
            m_count = co;
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        end else if (!iv) begin
            m_cur   = 16'h0000;
            m_count = 2'd0;
        end else begin
            m_cur   = mem[m_fpc];
            m_pc    = m_fpc;
            m_fpc   = m_fpc + 8'd1;
            m_count = 2'd0;
        end
        @(posedge clk);
        #1;
        if (chk) compare_all();
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0]    = 16'h4123;
        mem[1]    = 16'h5312;
        mem[8'h40] = 16'h7A5C;

        rst_n = 1'b0; imem_valid = 1'b0; control = 1'b0; count_out = 2'd0;
        redirect_valid = 1'b0; redirect_target = 8'h00;
        model_reset();
        #12;
        compare_all();
        @(negedge clk) rst_n = 1'b1;

        // Boot fetch of mem[0].
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("boot_current", 32'(current), 32'h4123);
        check("boot_addr", 32'(imem_addr), 32'h01);

        // Load-use stall on 16'h5312.
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("pre_stall_cur", 32'(current), 32'h5312);
        step(1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 1'b1);
        check("stall_count", 32'(count), 32'd1);
        check("stall_held", 32'(current), 32'h5312);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("stall_exit_pc", 32'(PC), 32'h02);
        check("stall_total", 32'(stall_cnt), 32'd1);

        // Advance to PC=5, then redirect to 0x40.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("pc5", 32'(PC), 32'h05);
        step(1'b1, 1'b0, 2'd0, 1'b1, 8'h40, 1'b1);
        check("redir_nop", 32'(current), 32'h0000);
        check("redir_addr", 32'(imem_addr), 32'h40);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("redir_fetch", 32'(current), 32'h7A5C);
        check("redir_pc", 32'(PC), 32'h40);

        // Redirect and stall together: redirect wins, stall not counted.
        step(1'b1, 1'b1, 2'd3, 1'b1, 8'h10, 1'b1);
        check("both_count", 32'(count), 32'd0);
        check("both_stall_cnt", 32'(stall_cnt), 32'd1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);

        // Three memory-wait cycles, then resume at the held address.
        held = imem_addr;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
            check("wait_nop", 32'(current), 32'h0000);
            check("wait_hold", 32'(imem_addr), 32'(held));
        end
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("wait_resume", 32'(PC), 32'(held));

        // Fetch pointer wrap.
        step(1'b1, 1'b0, 2'd0, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
        check("wrap_addr", 32'(imem_addr), 32'h00);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 4) == 0),
                 2'($urandom), 1'($urandom_range(0, 9) == 0), 8'($urandom), 1'b1);
        end

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        imem_valid = 1'b0; control = 1'b0; redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);

        // Saturate the stall counter.
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0, 8'h00, 1'b0);
        compare_all();
        check("stall_sat", 32'(stall_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
